// File: rtl/mips_pkg.sv
// Shared MIPS decode constants for the ID/EX stage and its decoder.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR = 6'h08;

  localparam logic [4:0] REG_RA = 5'd31;

  // Opcodes whose rt field is a source operand rather than a destination.
  function automatic logic op_reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decode: source fields, destination, control bits, immediate.
module id_decode #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
  input  logic [31:0]       instr,
  output logic [ADDR_W-1:0] rs_addr,
  output logic [ADDR_W-1:0] rt_addr,
  output logic [ADDR_W-1:0] dest,
  output logic              reg_write,
  output logic              mem_read,
  output logic              uses_rt,
  output logic [DATA_W-1:0] imm
);
  import mips_pkg::*;

  logic [5:0] w_op;

  assign w_op      = instr[31:26];
  assign rs_addr   = ADDR_W'(instr[25:21]);
  assign rt_addr   = ADDR_W'(instr[20:16]);
  assign mem_read  = (w_op == OP_LW);
  assign uses_rt   = op_reads_rt(w_op);
  assign imm       = {{(DATA_W-16){instr[15]}}, instr[15:0]};

  // Destination register select; jr and non-writing opcodes leave dest at 0.
  always_comb begin
    dest      = '0;
    reg_write = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        if (instr[5:0] != FN_JR) begin
          dest      = ADDR_W'(instr[15:11]);
          reg_write = 1'b1;
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
        dest      = ADDR_W'(instr[20:16]);
        reg_write = 1'b1;
      end
      OP_JAL: begin
        dest      = ADDR_W'(REG_RA);
        reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use stall and stall counter.
module id_ex_stage #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  output logic              read_enabled,
  output logic [ADDR_W-1:0] read_addr_s,
  output logic [ADDR_W-1:0] read_addr_t,
  input  logic [DATA_W-1:0] rf_data_s,
  input  logic [DATA_W-1:0] rf_data_t,
  input  logic              wb_write_enabled,
  input  logic [ADDR_W-1:0] wb_write_addr,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              ex_ready,
  output logic [31:0]       out_pc,
  output logic [DATA_W-1:0] out_rs_val,
  output logic [DATA_W-1:0] out_rt_val,
  output logic [DATA_W-1:0] out_imm,
  output logic [5:0]        out_opcode,
  output logic [5:0]        out_funct,
  output logic [ADDR_W-1:0] out_dest,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic [31:0]       stall_count
);

  logic [ADDR_W-1:0] w_rs_addr;
  logic [ADDR_W-1:0] w_rt_addr;
  logic [ADDR_W-1:0] w_dest;
  logic              w_reg_write;
  logic              w_mem_read;
  logic              w_uses_rt;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic              w_advance;
  logic              w_hazard;

  logic              r_valid;
  logic [31:0]       r_pc;
  logic [DATA_W-1:0] r_rs_val;
  logic [DATA_W-1:0] r_rt_val;
  logic [DATA_W-1:0] r_imm;
  logic [5:0]        r_opcode;
  logic [5:0]        r_funct;
  logic [ADDR_W-1:0] r_dest;
  logic              r_reg_write;
  logic              r_mem_read;
  logic [31:0]       r_stall_count;

  id_decode #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_decode (
    .instr    (in_instr),
    .rs_addr  (w_rs_addr),
    .rt_addr  (w_rt_addr),
    .dest     (w_dest),
    .reg_write(w_reg_write),
    .mem_read (w_mem_read),
    .uses_rt  (w_uses_rt),
    .imm      (w_imm)
  );

  assign read_enabled = in_valid;
  assign read_addr_s  = w_rs_addr;
  assign read_addr_t  = w_rt_addr;

  // Operand capture: r0 is hard zero, then same-cycle writeback wins over the file.
  always_comb begin
    w_rs_val = rf_data_s;
    w_rt_val = rf_data_t;
    if (w_rs_addr == '0) begin
      w_rs_val = '0;
    end else if (wb_write_enabled && (wb_write_addr != '0) && (wb_write_addr == w_rs_addr)) begin
      w_rs_val = wb_write_data;
    end
    if (w_rt_addr == '0) begin
      w_rt_val = '0;
    end else if (wb_write_enabled && (wb_write_addr != '0) && (wb_write_addr == w_rt_addr)) begin
      w_rt_val = wb_write_data;
    end
  end

  assign w_advance = !r_valid || ex_ready;

  // A load sitting in this stage cannot forward to the instruction behind it.
  assign w_hazard = r_valid && r_mem_read && (r_dest != '0) &&
                    ((r_dest == w_rs_addr) || ((r_dest == w_rt_addr) && w_uses_rt));

  assign in_ready = !reset && (flush || (w_advance && !w_hazard));

  // Stage register: reset, then flush, then bubble-or-capture when downstream can take it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid       <= 1'b0;
      r_pc          <= '0;
      r_rs_val      <= '0;
      r_rt_val      <= '0;
      r_imm         <= '0;
      r_opcode      <= '0;
      r_funct       <= '0;
      r_dest        <= '0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_stall_count <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_advance) begin
      if (w_hazard) begin
        r_valid <= 1'b0;
        if (r_stall_count != 32'hFFFF_FFFF) begin
          r_stall_count <= r_stall_count + 32'd1;
        end
      end else begin
        r_valid     <= in_valid;
        r_pc        <= in_pc;
        r_rs_val    <= w_rs_val;
        r_rt_val    <= w_rt_val;
        r_imm       <= w_imm;
        r_opcode    <= in_instr[31:26];
        r_funct     <= in_instr[5:0];
        r_dest      <= w_dest;
        r_reg_write <= w_reg_write;
        r_mem_read  <= w_mem_read;
      end
    end
  end

  assign out_valid     = r_valid;
  assign out_pc        = r_pc;
  assign out_rs_val    = r_rs_val;
  assign out_rt_val    = r_rt_val;
  assign out_imm       = r_imm;
  assign out_opcode    = r_opcode;
  assign out_funct     = r_funct;
  assign out_dest      = r_dest;
  assign out_reg_write = r_reg_write;
  assign out_mem_read  = r_mem_read;
  assign stall_count   = r_stall_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic vs a model.
module tb_id_ex_stage;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        read_enabled;
  logic [4:0]  read_addr_s;
  logic [4:0]  read_addr_t;
  logic [31:0] rf_data_s;
  logic [31:0] rf_data_t;
  logic        wb_write_enabled;
  logic [4:0]  wb_write_addr;
  logic [31:0] wb_write_data;
  logic        flush;
  logic        out_valid;
  logic        ex_ready;
  logic [31:0] out_pc;
  logic [31:0] out_rs_val;
  logic [31:0] out_rt_val;
  logic [31:0] out_imm;
  logic [5:0]  out_opcode;
  logic [5:0]  out_funct;
  logic [4:0]  out_dest;
  logic        out_reg_write;
  logic        out_mem_read;
  logic [31:0] stall_count;

  int n_checks = 0;
  int n_errors = 0;

  id_ex_stage #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instr        (in_instr),
    .in_pc           (in_pc),
    .read_enabled    (read_enabled),
    .read_addr_s     (read_addr_s),
    .read_addr_t     (read_addr_t),
    .rf_data_s       (rf_data_s),
    .rf_data_t       (rf_data_t),
    .wb_write_enabled(wb_write_enabled),
    .wb_write_addr   (wb_write_addr),
    .wb_write_data   (wb_write_data),
    .flush           (flush),
    .out_valid       (out_valid),
    .ex_ready        (ex_ready),
    .out_pc          (out_pc),
    .out_rs_val      (out_rs_val),
    .out_rt_val      (out_rt_val),
    .out_imm         (out_imm),
    .out_opcode      (out_opcode),
    .out_funct       (out_funct),
    .out_dest        (out_dest),
    .out_reg_write   (out_reg_write),
    .out_mem_read    (out_mem_read),
    .stall_count     (stall_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference view of what the execute stage should be holding.
  typedef struct {
    logic        valid;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic [31:0] cnt;
  } model_t;

  model_t m;

  task automatic ref_decode(input logic [31:0] ins, output logic [4:0] dest, output logic rw,
                            output logic mr, output logic rrt);
    logic [5:0] op;
    op   = ins[31:26];
    dest = 5'd0;
    rw   = 1'b0;
    if (op == 6'h00 && ins[5:0] != 6'h08) begin
      dest = ins[15:11];
      rw   = 1'b1;
    end else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23}) begin
      dest = ins[20:16];
      rw   = 1'b1;
    end else if (op == 6'h03) begin
      dest = 5'd31;
      rw   = 1'b1;
    end
    mr  = (op == 6'h23);
    rrt = op inside {6'h00, 6'h04, 6'h05, 6'h2B};
  endtask

  function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
    if (wb_write_enabled && wb_write_addr == a) return wb_write_data;
    return rf;
  endfunction

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic tick();
    logic [4:0] rs, rt, d;
    logic       rw, mr, rrt, adv, haz;
    model_t     n;
    rs = in_instr[25:21];
    rt = in_instr[20:16];
    ref_decode(in_instr, d, rw, mr, rrt);
    adv = !m.valid || ex_ready;
    haz = m.valid && m.mr && m.dest != 5'd0 && (m.dest == rs || (m.dest == rt && rrt));
    #1;
    check("in_ready", 32'(in_ready), 32'(reset ? 1'b0 : (flush ? 1'b1 : (adv && !haz))));
    check("read_enabled", 32'(read_enabled), 32'(in_valid));
    check("read_addr_s", 32'(read_addr_s), 32'(rs));
    check("read_addr_t", 32'(read_addr_t), 32'(rt));
    n     = m;
    n.rst = 1'b0;
    if (reset) begin
      n = '{valid: 1'b0, rst: 1'b1, pc: 0, rs: 0, rt: 0, imm: 0, op: 0, fn: 0, dest: 0,
            rw: 1'b0, mr: 1'b0, cnt: 0};
    end else if (flush) begin
      n.valid = 1'b0;
    end else if (adv) begin
      if (haz) begin
        n.valid = 1'b0;
        if (m.cnt != 32'hFFFF_FFFF) n.cnt = m.cnt + 1;
      end else begin
        n.valid = in_valid;
        n.pc    = in_pc;
        n.rs    = ref_operand(rs, rf_data_s);
        n.rt    = ref_operand(rt, rf_data_t);
        n.imm   = 32'($signed(in_instr[15:0]));
        n.op    = in_instr[31:26];
        n.fn    = in_instr[5:0];
        n.dest  = d;
        n.rw    = rw;
        n.mr    = mr;
      end
    end
    @(posedge clock);
    #1;
    m = n;
    check("out_valid", 32'(out_valid), 32'(m.valid));
    check("stall_count", stall_count, m.cnt);
    if (m.valid || m.rst) begin
      check("out_pc", out_pc, m.pc);
      check("out_rs_val", out_rs_val, m.rs);
      check("out_rt_val", out_rt_val, m.rt);
      check("out_imm", out_imm, m.imm);
      check("out_opcode", 32'(out_opcode), 32'(m.op));
      check("out_funct", 32'(out_funct), 32'(m.fn));
      check("out_dest", 32'(out_dest), 32'(m.dest));
      check("out_reg_write", 32'(out_reg_write), 32'(m.rw));
      check("out_mem_read", 32'(out_mem_read), 32'(m.mr));
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [5:0]  op;
    case ($urandom_range(0, 9))
      0, 1:    op = 6'h00;
      2, 3:    op = 6'h23;
      4:       op = 6'h08;
      5:       op = 6'h03;
      6:       op = 6'h04;
      7:       op = 6'h2B;
      8:       op = 6'h0F;
      default: op = 6'($urandom);
    endcase
    ins          = $urandom;
    ins[31:26]   = op;
    ins[25:21]   = 5'($urandom_range(0, 7));
    ins[20:16]   = 5'($urandom_range(0, 7));
    ins[15:11]   = 5'($urandom_range(0, 7));
    if (op == 6'h00 && $urandom_range(0, 3) == 0) ins[5:0] = 6'h08;
    return ins;
  endfunction

  localparam logic [31:0] I_ADD_3_8_9 = 32'h0109_1820;  // add r3,r8,r9
  localparam logic [31:0] I_ADD_3_0_9 = 32'h0009_1820;  // add r3,r0,r9
  localparam logic [31:0] I_LW_4_1    = 32'h8C24_0000;  // lw r4,0(r1)
  localparam logic [31:0] I_ADD_5_4_2 = 32'h0082_2820;  // add r5,r4,r2
  localparam logic [31:0] I_ADDI_6_1  = 32'h2026_0005;  // addi r6,r1,5

  initial begin
    m = '{valid: 1'b0, rst: 1'b0, pc: 0, rs: 0, rt: 0, imm: 0, op: 0, fn: 0, dest: 0,
          rw: 1'b0, mr: 1'b0, cnt: 0};
    reset = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    in_valid = 1'b1; in_instr = I_ADD_3_8_9; in_pc = 32'h0000_1000;
    rf_data_s = 32'h1234_5678; rf_data_t = 32'h9ABC_DEF0;
    wb_write_enabled = 1'b1; wb_write_addr = 5'd8; wb_write_data = 32'h5555_AAAA;

    // Reset with a valid instruction presented.
    #1 check("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_stall", stall_count, 32'd0);
    check("rst_rs", out_rs_val, 32'd0);
    check("rst_dest", 32'(out_dest), 32'd0);
    check("rst_pc", out_pc, 32'd0);

    // Same-cycle writeback bypass.
    reset = 1'b0;
    rf_data_s = 32'h1111_1111; rf_data_t = 32'h2222_2222;
    wb_write_enabled = 1'b1; wb_write_addr = 5'd8; wb_write_data = 32'hDEAD_BEEF;
    in_instr = I_ADD_3_8_9; in_pc = 32'h0000_1004;
    tick();
    check("byp_rs", out_rs_val, 32'hDEAD_BEEF);
    check("byp_rt", out_rt_val, 32'h2222_2222);
    check("byp_dest", 32'(out_dest), 32'd3);
    check("byp_rw", 32'(out_reg_write), 32'd1);

    // Register zero ignores both file data and a write to r0.
    wb_write_addr = 5'd0;
    in_instr = I_ADD_3_0_9; in_pc = 32'h0000_1008;
    tick();
    check("r0_rs", out_rs_val, 32'd0);

    // Load-use: one bubble, then the dependent add issues.
    wb_write_enabled = 1'b0;
    in_instr = I_LW_4_1; in_pc = 32'h0000_100C;
    tick();
    check("lu_lw_mr", 32'(out_mem_read), 32'd1);
    check("lu_lw_dest", 32'(out_dest), 32'd4);
    in_instr = I_ADD_5_4_2; in_pc = 32'h0000_1010;
    #1 check("lu_stall_ready", 32'(in_ready), 32'd0);
    tick();
    check("lu_bubble", 32'(out_valid), 32'd0);
    check("lu_count", stall_count, 32'd1);
    #1 check("lu_retry_ready", 32'(in_ready), 32'd1);
    tick();
    check("lu_issue_valid", 32'(out_valid), 32'd1);
    check("lu_issue_dest", 32'(out_dest), 32'd5);

    // Backpressure for three cycles, then resume.
    ex_ready = 1'b0;
    in_instr = I_ADDI_6_1; in_pc = 32'h0000_1014;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready", 32'(in_ready), 32'd0);
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_dest", 32'(out_dest), 32'd5);
    end
    ex_ready = 1'b1;
    tick();
    check("bp_resume_dest", 32'(out_dest), 32'd6);
    check("bp_resume_imm", out_imm, 32'd5);

    // Flush while a load-use hazard is pending.
    in_instr = I_LW_4_1; in_pc = 32'h0000_1018;
    tick();
    in_instr = I_ADD_5_4_2; in_pc = 32'h0000_101C; flush = 1'b1;
    #1 check("fl_ready", 32'(in_ready), 32'd1);
    tick();
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_count", stall_count, 32'd1);
    flush = 1'b0;

    // Reset in the middle of a stall leaves no residual bubble.
    in_instr = I_LW_4_1;
    tick();
    in_instr = I_ADD_5_4_2; reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 check("rs_mid_ready", 32'(in_ready), 32'd1);
    tick();
    check("rs_mid_valid", 32'(out_valid), 32'd1);
    check("rs_mid_count", stall_count, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      reset            = ($urandom_range(0, 49) == 0);
      flush            = ($urandom_range(0, 11) == 0);
      ex_ready         = ($urandom_range(0, 3) != 0);
      in_valid         = ($urandom_range(0, 3) != 0);
      in_instr         = rand_instr();
      in_pc            = $urandom;
      rf_data_s        = $urandom;
      rf_data_t        = $urandom;
      wb_write_enabled = $urandom_range(0, 1) == 1;
      wb_write_addr    = 5'($urandom_range(0, 7));
      wb_write_data    = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
